// File: rtl/disp_settings_ctrl.sv
// Push-button front end for the character display: four synchronised and debounced
// buttons step the character index, move speed, colour palette and flash enable.
module disp_settings_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int FLASH_HALF_PERIOD = 12500000,
    parameter int CHAR_COUNT        = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btnChar,
    input  logic       btnSpeed,
    input  logic       btnColor,
    input  logic       btnFlash,
    output logic [3:0] charOffset,
    output logic [3:0] moveSpeed,
    output logic [8:0] charRgbDepth,
    output logic [8:0] bkRgbDepth,
    output logic       flashClk
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FL_W = (FLASH_HALF_PERIOD > 1) ? $clog2(FLASH_HALF_PERIOD) : 1;
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FL_W-1:0] FL_LAST   = FL_W'(FLASH_HALF_PERIOD - 1);
    localparam logic [3:0]      CHAR_LAST = 4'(CHAR_COUNT - 1);

    logic [3:0] btn_raw;
    logic [3:0] press;

    assign btn_raw = {btnFlash, btnColor, btnSpeed, btnChar};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            db_reg;
            logic            press_reg;
            logic [DB_W-1:0] cnt_reg;

            // press_reg is registered alongside the rising flip of db_reg, which is
            // exactly db & ~db_prev one cycle later.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    db_reg    <= 1'b0;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg != db_reg) begin
                        if (cnt_reg == DB_LAST) begin
                            db_reg    <= sync2_reg;
                            cnt_reg   <= '0;
                            press_reg <= sync2_reg;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    function automatic logic [17:0] palette_lut(input logic [2:0] idx);
        logic [17:0] pair;
        pair = {9'h1FF, 9'h000};
        case (idx)
            3'd0: pair = {9'h1FF, 9'h000};
            3'd1: pair = {9'h1C0, 9'h000};
            3'd2: pair = {9'h038, 9'h000};
            3'd3: pair = {9'h007, 9'h000};
            3'd4: pair = {9'h000, 9'h1FF};
            3'd5: pair = {9'h1F8, 9'h007};
            3'd6: pair = {9'h1C7, 9'h038};
            3'd7: pair = {9'h03F, 9'h1C0};
            default: pair = {9'h1FF, 9'h000};
        endcase
        return pair;
    endfunction

    logic [2:0]  pal_idx_reg;
    logic [2:0]  pal_next;
    logic [17:0] pal_pair;

    // Look up the colour of the incoming index so colours change on the same edge.
    assign pal_next = pal_idx_reg + 3'd1;
    assign pal_pair = palette_lut(pal_next);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            charOffset   <= 4'd0;
            moveSpeed    <= 4'd1;
            pal_idx_reg  <= 3'd0;
            charRgbDepth <= 9'h1FF;
            bkRgbDepth   <= 9'h000;
        end else begin
            if (press[0]) begin
                charOffset <= (charOffset == CHAR_LAST) ? 4'd0 : charOffset + 4'd1;
            end
            if (press[1]) begin
                moveSpeed <= moveSpeed + 4'd1;
            end
            if (press[2]) begin
                pal_idx_reg  <= pal_next;
                charRgbDepth <= pal_pair[17:9];
                bkRgbDepth   <= pal_pair[8:0];
            end
        end
    end

    logic            flash_en_reg;
    logic [FL_W-1:0] flash_cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flash_en_reg  <= 1'b0;
            flash_cnt_reg <= '0;
            flashClk      <= 1'b1;
        end else begin
            if (press[3]) begin
                flash_en_reg <= ~flash_en_reg;
            end
            // Disabling wins immediately, even in the middle of a dark half period.
            if (!flash_en_reg || (press[3] && flash_en_reg)) begin
                flash_cnt_reg <= '0;
                flashClk      <= 1'b1;
            end else if (flash_cnt_reg == FL_LAST) begin
                flash_cnt_reg <= '0;
                flashClk      <= ~flashClk;
            end else begin
                flash_cnt_reg <= flash_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: doc/disp_settings_ctrl.md
# disp_settings_ctrl

User-settings front end for the VGA character display: turns four raw push-buttons into the control inputs the display controller consumes. It drives `charOffset`, `moveSpeed`, `charRgbDepth`, `bkRgbDepth` and `flashClk`. Each button is synchronised, debounced and edge-detected, then steps one register: a wrapping counter, a palette index, or the flash enable. It sits directly upstream of the display controller, in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive cycles a synchronised button level must differ from its debounced state before being accepted (10 ms at 50 MHz).
- `FLASH_HALF_PERIOD`, default 12500000: cycles per `flashClk` half period.
- `CHAR_COUNT`, default 10: number of selectable characters; `charOffset` wraps at `CHAR_COUNT-1`.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `btnChar`  in  1  raw button, active-high, asynchronous to `clock`.
- `btnSpeed`  in  1  raw button, active-high, asynchronous.
- `btnColor`  in  1  raw button, active-high, asynchronous.
- `btnFlash`  in  1  raw button, active-high, asynchronous.
- `charOffset`  out  4  selected character index.
- `moveSpeed`  out  4  movement speed; 0 = stationary.
- `charRgbDepth`  out  9  character colour, RRRGGGBBB.
- `bkRgbDepth`  out  9  background colour, RRRGGGBBB.
- `flashClk`  out  1  flash gate; 1 = character visible.

## Operation
- **Per-button front end:**
  - 2-flop synchroniser.
  - Debouncer: debounced state plus a counter sized for `DEBOUNCE_CYCLES`. The counter increments on each edge where the synchronised level differs from the debounced state. It clears on any edge where they are equal. The debounced state flips on the edge where the count reaches `DEBOUNCE_CYCLES`, and the counter clears on that same edge.
  - Press pulse = debounced & ~debounced_prev, exactly 1 cycle wide.
  - Releases are debounced the same way and generate no pulse. A held button yields exactly one press.
- **charOffset:** +1 per `btnChar` press; `CHAR_COUNT-1` → 0.
- **moveSpeed:** +1 per `btnSpeed` press; 15 → 0.
- **Palette:** 3-bit index, +1 per `btnColor` press, 7 → 0. Outputs are registered lookups in (char/bk) order:
  - 0: 1FF/000
  - 1: 1C0/000
  - 2: 038/000
  - 3: 007/000
  - 4: 000/1FF
  - 5: 1F8/007
  - 6: 1C7/038
  - 7: 03F/1C0
- **Flash:** `btnFlash` press toggles `flashEn`.
  - While `flashEn` = 1: a counter runs 0..`FLASH_HALF_PERIOD-1`. At the terminal count `flashClk` toggles and the counter returns to 0. Full period = 2·`FLASH_HALF_PERIOD` cycles.
  - While `flashEn` = 0: counter held at 0, `flashClk` held at 1.
- **Simultaneous presses:** on different buttons, presses are independent and all take effect on the same edge.
- **Reset values (asynchronous):**
  - synchronisers, debounced states, debounce counters, press pulses: 0
  - `charOffset` 0, `moveSpeed` 1, palette index 0 (`charRgbDepth` 1FF, `bkRgbDepth` 000)
  - `flashEn` 0, flash counter 0, `flashClk` 1
- **Button held through reset release:** debounced state restarts at 0, so the press registers `DEBOUNCE_CYCLES` after release.
- **Reset mid-debounce or mid-flash:** all partial counts are discarded. No press is generated from a pre-reset level change.

## Timing
- **Press latency:** let k0 be the first edge at which synchroniser stage 1 captures 1.
  - Stage 2 captures 1 at k0+1.
  - Debounced state rises at edge k0+1+`DEBOUNCE_CYCLES`.
  - Press pulse is high during the following cycle.
  - The target output register changes at edge k0+2+`DEBOUNCE_CYCLES`.
- **Bounce:** any glitch shorter than `DEBOUNCE_CYCLES` cycles (measured at stage 2) produces no output change.
- **Flash enable:** the flash counter starts from 0 on the edge after the flashEn-setting edge. The first `flashClk` fall occurs `FLASH_HALF_PERIOD` edges later.
- **Flash disable mid-period:** counter cleared and `flashClk` = 1 on the edge that clears `flashEn`. This applies even if `flashClk` was 0.
- **Glitch-free outputs:** all outputs come straight from registers, with no combinational path from buttons to outputs.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `FLASH_HALF_PERIOD`=6, `CHAR_COUNT`=10.
1. **Reset:** assert reset mid-run → immediately `charOffset`=0, `moveSpeed`=1, `charRgbDepth`=1FF, `bkRgbDepth`=000, `flashClk`=1.
2. **Debounce:**
   - `btnChar` high for 3 cycles at stage 2, then low → `charOffset` stays 0.
   - Held 20 cycles → `charOffset`=1 exactly at k0+6 and stays 1 after release.
3. **Wrap:**
   - 10 clean `btnChar` presses → `charOffset` 0→…→9→0.
   - 15 clean `btnSpeed` presses from reset → `moveSpeed` 1→…→15→0.
4. **Palette:** 8 `btnColor` presses → pairs 1C0/000, 038/000, 007/000, 000/1FF, 1F8/007, 1C7/038, 03F/1C0, 1FF/000 in order.
5. **Flash:**
   - One `btnFlash` press → `flashClk` toggles every 6 cycles (period 12).
   - Second press while `flashClk`=0 → `flashClk`=1 on that edge and held.
6. **Simultaneous and held-through-reset:**
   - `btnChar` and `btnColor` pressed on the same cycle → both update on the same edge.
   - Button held through reset release → one press exactly 4 cycles after stage 2 sees it.
